// File: rtl/game_pkg.sv
// game_pkg: shared encoding and widths for the round controller and sequencer
package game_pkg;
  localparam int DEPTH_DEF = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;
  localparam int ROUND_W = 6;
  typedef enum logic [3:0] {IDLE, GEN, SHOW_RD, SHOW_ON, SHOW_GAP, IN_RD, IN_WAIT, WIN, LOSE} state_t;
endpackage

// File: rtl/round_controller_if.sv
// round_controller_if: sequencer handshake, sequence RAM read port, display and player buttons
interface round_controller_if;
  import game_pkg::*;
  logic gen_start;
  logic gen_finish;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic show_valid;
  logic [DATA_W-1:0] show_value;
  logic btn_valid;
  logic [DATA_W-1:0] btn_value;
  modport master(output gen_start, rd_addr, show_valid, show_value, input gen_finish, rd_data, btn_valid, btn_value);
  modport slave(input gen_start, rd_addr, show_valid, show_value, output gen_finish, rd_data, btn_valid, btn_value);
endinterface

// File: rtl/round_controller_phase_timer.sv
// phase_timer: loadable down-counter, done while the count sits at zero
module phase_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == '0;
endmodule

// File: rtl/round_controller.sv
// round_controller: memory-game FSM that plays back a growing sequence and checks player entries
module round_controller
  import game_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int SHOW_CYCLES = 8,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  round_controller_if.master  bus,
  output logic [ROUND_W-1:0]  round,
  output logic                busy,
  output logic                win,
  output logic                lose
);
  localparam int TMAX = SHOW_CYCLES > GAP_CYCLES ? (SHOW_CYCLES > TIMEOUT_CYCLES ? SHOW_CYCLES : TIMEOUT_CYCLES)
                                                 : (GAP_CYCLES > TIMEOUT_CYCLES ? GAP_CYCLES : TIMEOUT_CYCLES);
  localparam int TW = $clog2(TMAX) < 1 ? 1 : $clog2(TMAX);
  localparam logic [ROUND_W-1:0] DEPTH_R = ROUND_W'(DEPTH);
  state_t state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [ROUND_W-1:0] round_n, idx_inc;
  logic [DATA_W-1:0] value;
  logic t_load, t_done;
  logic [TW-1:0] t_val;
  assign idx_inc = ROUND_W'(idx) + 1'b1;
  // every state change restarts the timer with the length of the state being entered
  assign t_load = state_n != state;
  assign t_val = state_n == SHOW_ON ? TW'(SHOW_CYCLES - 1) : state_n == SHOW_GAP ? TW'(GAP_CYCLES - 1) : TW'(TIMEOUT_CYCLES - 1);
  phase_timer #(.W(TW)) u_timer (.clk(clk), .rst(rst), .load(t_load), .load_val(t_val), .done(t_done));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      round <= '0;
      value <= '0;
      bus.rd_addr <= '0;
      bus.gen_start <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      round <= round_n;
      bus.gen_start <= state_n == GEN && state != GEN;
      if (state == SHOW_RD) value <= bus.rd_data;
      if (state_n == SHOW_RD || state_n == IN_RD) bus.rd_addr <= idx_n;
    end
  always_comb begin
    state_n = state;
    idx_n = idx;
    round_n = round;
    case (state)
      IDLE, WIN, LOSE: if (go) begin
        state_n = GEN;
        round_n = '0;
      end
      GEN: if (bus.gen_finish) begin
        state_n = SHOW_RD;
        round_n = ROUND_W'(1);
        idx_n = '0;
      end
      SHOW_RD: state_n = SHOW_ON;
      SHOW_ON: state_n = t_done ? SHOW_GAP : SHOW_ON;
      SHOW_GAP: if (t_done) begin
        state_n = idx_inc == round ? IN_RD : SHOW_RD;
        idx_n = idx_inc == round ? '0 : idx + 1'b1;
      end
      IN_RD: state_n = IN_WAIT;
      IN_WAIT:
        if (bus.btn_valid && bus.btn_value != bus.rd_data) state_n = LOSE;
        else if (bus.btn_valid) begin
          if (idx_inc < round) begin
            state_n = IN_RD;
            idx_n = idx + 1'b1;
          end else if (round == DEPTH_R) state_n = WIN;
          else begin
            state_n = SHOW_RD;
            round_n = round + 1'b1;
            idx_n = '0;
          end
        end else if (t_done) state_n = LOSE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    bus.show_valid = state == SHOW_ON;
    bus.show_value = state == SHOW_ON ? value : '0;
    busy = !(state inside {IDLE, WIN, LOSE});
    win = state == WIN;
    lose = state == LOSE;
  end
endmodule

// File: tb/tb_round_controller.sv
// tb_round_controller: randomized game play checked against a sequence-level model of the rules
module tb_round_controller;
  import game_pkg::*;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic go = 1'b0;
  logic [5:0] round;
  logic busy, win, lose;
  logic [3:0] mem [0:31];
  int total = 0;
  int bad = 0;
  round_controller_if bus();
  round_controller #(.DEPTH(D)) dut (.clk(clk), .rst(rst), .go(go), .bus(bus), .round(round), .busy(busy), .win(win), .lose(lose));
  always #5 clk = ~clk;
  assign bus.rd_data = mem[bus.rd_addr];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    go = 1'b1;
    step();
    step();
    total++;
    if ({bus.gen_start, bus.rd_addr, bus.show_valid, bus.show_value, round, busy, win, lose} !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs act=%h exp=0", {bus.gen_start, bus.rd_addr, bus.show_valid, bus.show_value, round, busy, win, lose});
    end
    go = 1'b0;
    rst = 1'b0;
    bus.gen_finish = 1'b1;
    bus.btn_valid = 1'b1;
    step();
    bus.gen_finish = 1'b0;
    bus.btn_valid = 1'b0;
    step();
    total++;
    if ({bus.gen_start, busy, round, win, lose} !== 10'h0) begin
      bad++;
      $display("FAIL idle_ignore act=%h exp=0", {bus.gen_start, busy, round, win, lose});
    end
  endtask

  task automatic begin_game();
    go = 1'b1;
    step();
    go = 1'b0;
    total++;
    if ({bus.gen_start, busy, round, win, lose} !== {1'b1, 1'b1, 6'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL gen_enter act=%h exp=%h", {bus.gen_start, busy, round, win, lose}, {1'b1, 1'b1, 6'd0, 1'b0, 1'b0});
    end
    for (int i = 0; i < 32; i++) mem[i] = 4'($urandom);
  endtask

  task automatic finish_gen(input int delay);
    for (int c = 1; c < delay; c++) begin
      step();
      total++;
      if ({bus.gen_start, busy, round} !== {1'b0, 1'b1, 6'd0}) begin
        bad++;
        $display("FAIL gen_wait c=%0d act=%h exp=%h", c, {bus.gen_start, busy, round}, {1'b0, 1'b1, 6'd0});
      end
    end
    bus.gen_finish = 1'b1;
    step();
    bus.gen_finish = 1'b0;
    total++;
    if ({busy, round, bus.rd_addr, bus.show_valid} !== {1'b1, 6'd1, 5'd0, 1'b0}) begin
      bad++;
      $display("FAIL gen_done act=%h exp=%h", {busy, round, bus.rd_addr, bus.show_valid}, {1'b1, 6'd1, 5'd0, 1'b0});
    end
  endtask

  task automatic play_round(input int r);
    for (int i = 0; i < r; i++) begin
      total++;
      if ({bus.show_valid, bus.rd_addr, round} !== {1'b0, 5'(i), 6'(r)}) begin
        bad++;
        $display("FAIL show_rd r=%0d i=%0d act=%h exp=%h", r, i, {bus.show_valid, bus.rd_addr, round}, {1'b0, 5'(i), 6'(r)});
      end
      step();
      for (int c = 0; c < 8; c++) begin
        total++;
        if ({bus.show_valid, bus.show_value, round, lose} !== {1'b1, mem[i], 6'(r), 1'b0}) begin
          bad++;
          $display("FAIL show_on r=%0d i=%0d c=%0d act=%h exp=%h", r, i, c, {bus.show_valid, bus.show_value, round, lose}, {1'b1, mem[i], 6'(r), 1'b0});
        end
        if (i == 0 && c == 3) begin
          go = 1'b1;
          bus.btn_valid = 1'b1;
          bus.btn_value = mem[i] ^ 4'h6;
          bus.gen_finish = 1'b1;
        end
        step();
        go = 1'b0;
        bus.btn_valid = 1'b0;
        bus.gen_finish = 1'b0;
      end
      for (int c = 0; c < 4; c++) begin
        total++;
        if ({bus.show_valid, bus.show_value, busy} !== 6'b000001) begin
          bad++;
          $display("FAIL show_gap r=%0d i=%0d c=%0d act=%h exp=01", r, i, c, {bus.show_valid, bus.show_value, busy});
        end
        step();
      end
    end
    total++;
    if ({busy, bus.show_valid, bus.rd_addr, round} !== {1'b1, 1'b0, 5'd0, 6'(r)}) begin
      bad++;
      $display("FAIL in_rd r=%0d act=%h exp=%h", r, {busy, bus.show_valid, bus.rd_addr, round}, {1'b1, 1'b0, 5'd0, 6'(r)});
    end
  endtask

  task automatic play_inputs(input int r, input int bad_at);
    int delay;
    for (int i = 0; i < r; i++) begin
      step();
      delay = $urandom_range(0, 4);
      for (int k = 0; k < delay; k++) begin
        bus.gen_finish = k == 0;
        step();
        bus.gen_finish = 1'b0;
      end
      bus.btn_valid = 1'b1;
      bus.btn_value = i == bad_at ? mem[i] ^ 4'h6 : mem[i];
      step();
      bus.btn_valid = 1'b0;
      if (i == bad_at) begin
        total++;
        if ({lose, busy, win} !== 3'b100) begin
          bad++;
          $display("FAIL wrong_entry r=%0d i=%0d act=%b exp=100", r, i, {lose, busy, win});
        end
        return;
      end else if (i < r - 1) begin
        total++;
        if ({busy, lose, bus.rd_addr, round} !== {1'b1, 1'b0, 5'(i + 1), 6'(r)}) begin
          bad++;
          $display("FAIL next_entry r=%0d i=%0d act=%h exp=%h", r, i, {busy, lose, bus.rd_addr, round}, {1'b1, 1'b0, 5'(i + 1), 6'(r)});
        end
      end else if (r == D) begin
        total++;
        if ({win, busy, round, lose} !== {1'b1, 1'b0, 6'(D), 1'b0}) begin
          bad++;
          $display("FAIL win r=%0d act=%h exp=%h", r, {win, busy, round, lose}, {1'b1, 1'b0, 6'(D), 1'b0});
        end
      end else begin
        total++;
        if ({busy, bus.show_valid, bus.rd_addr, round} !== {1'b1, 1'b0, 5'd0, 6'(r + 1)}) begin
          bad++;
          $display("FAIL round_up r=%0d act=%h exp=%h", r, {busy, bus.show_valid, bus.rd_addr, round}, {1'b1, 1'b0, 5'd0, 6'(r + 1)});
        end
      end
    end
  endtask

  task automatic test_start();
    begin_game();
    mem[0] = 4'hA;
    mem[1] = 4'h3;
    finish_gen(10);
  endtask

  task automatic test_rounds();
    play_round(1);
    play_inputs(1, -1);
    play_round(2);
    play_inputs(2, -1);
    play_round(3);
    play_inputs(3, 1);
  endtask

  task automatic test_timeout();
    begin_game();
    finish_gen($urandom_range(1, 6));
    play_round(1);
    step();
    for (int k = 1; k <= 1024; k++) begin
      total++;
      if ({lose, busy} !== 2'b01) begin
        bad++;
        $display("FAIL timeout_wait k=%0d act=%b exp=01", k, {lose, busy});
      end
      step();
    end
    total++;
    if ({lose, busy, win} !== 3'b100) begin
      bad++;
      $display("FAIL timeout_lose act=%b exp=100", {lose, busy, win});
    end
    begin_game();
  endtask

  task automatic test_win();
    finish_gen($urandom_range(1, 6));
    for (int r = 1; r <= D; r++) begin
      play_round(r);
      play_inputs(r, -1);
    end
    for (int k = 0; k < 3; k++) begin
      bus.btn_valid = 1'b1;
      bus.btn_value = 4'($urandom);
      bus.gen_finish = k == 1;
      step();
      bus.btn_valid = 1'b0;
      bus.gen_finish = 1'b0;
      total++;
      if ({win, busy, round, lose, bus.gen_start} !== {1'b1, 1'b0, 6'(D), 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL win_hold k=%0d act=%h exp=%h", k, {win, busy, round, lose, bus.gen_start}, {1'b1, 1'b0, 6'(D), 1'b0, 1'b0});
      end
    end
  endtask

  task automatic test_async_reset();
    begin_game();
    finish_gen(3);
    step();
    step();
    total++;
    if (bus.show_valid !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_show act=%b exp=1", bus.show_valid);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.show_valid, bus.show_value, round, busy, bus.rd_addr, bus.gen_start} !== 18'h0) begin
      bad++;
      $display("FAIL async_reset act=%h exp=0", {bus.show_valid, bus.show_value, round, busy, bus.rd_addr, bus.gen_start});
    end
    step();
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      total++;
      if ({bus.gen_start, bus.show_valid, busy, round} !== 9'h0) begin
        bad++;
        $display("FAIL post_reset k=%0d act=%h exp=0", k, {bus.gen_start, bus.show_valid, busy, round});
      end
    end
  endtask

  initial begin
    bus.gen_finish = 1'b0;
    bus.btn_valid = 1'b0;
    bus.btn_value = 4'h0;
    for (int i = 0; i < 32; i++) mem[i] = 4'h0;
    #1 rst = 1'b1;
    test_reset();
    test_start();
    test_rounds();
    test_timeout();
    test_win();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
